// File: rtl/seg7_scan_driver_if.sv
// Processor-side bundle for the multiplexed 7-segment driver.
// The host (master) drives the value and control lines; the driver (slave) returns status and pin levels.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 14
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  load;
    logic                  hex_mode;
    logic [BIN_WIDTH-1:0]  value;
    logic [NUM_DIGITS-1:0] dp;
    logic                  enable;
    logic                  busy;
    logic                  overflow;
    logic [IDX_W-1:0]      digit_idx;
    logic [7:0]            seg_n;
    logic [NUM_DIGITS-1:0] an_n;

    modport master (
        output load, hex_mode, value, dp, enable,
        input  busy, overflow, digit_idx, seg_n, an_n
    );

    modport slave (
        input  load, hex_mode, value, dp, enable,
        output busy, overflow, digit_idx, seg_n, an_n
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit 7-segment driver: hex or decimal (sequential double-dabble) rendering,
// leading-zero blanking, and a prescaled scan driving active-low segment and anode pins.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_WIDTH   = 14,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    seg7_scan_driver_if.slave    io_bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int BCD_W = DIG_W + 4;
    localparam int EXT_W = (BIN_WIDTH > DIG_W) ? BIN_WIDTH : DIG_W;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1110011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    logic [BIN_WIDTH-1:0]       r_val;
    logic                       r_hex_pend;
    logic                       r_busy;
    logic [CNT_W-1:0]           r_cnt;
    logic [BCD_W-1:0]           r_bcd;
    logic                       r_lost;
    logic [NUM_DIGITS-1:0]      r_dp_cap;
    logic [NUM_DIGITS-1:0][3:0] r_digits;
    logic                       r_ovf;
    logic [NUM_DIGITS-1:0]      r_dp_disp;
    logic [PRE_W-1:0]           r_presc;
    logic [IDX_W-1:0]           r_idx;
    logic [7:0]                 r_seg;
    logic [NUM_DIGITS-1:0]      r_an;

    logic [BCD_W-1:0]           w_bcd_adj;
    logic [BCD_W-1:0]           w_bcd_next;
    logic [EXT_W-1:0]           w_ext;
    logic                       w_hex_ovf;
    logic [NUM_DIGITS-1:0]      w_lz;
    logic                       w_step;
    logic [IDX_W-1:0]           w_idx_next;
    logic [6:0]                 w_glyph;

    // One double-dabble step; a 1 leaving the carry nibble is remembered so huge values still overflow
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
        w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_val[BIN_WIDTH-1]};
        w_ext      = EXT_W'(r_val);
        w_hex_ovf  = ((w_ext >> DIG_W) != '0);
    end

    // w_lz[i] marks that digit i and every digit above it are zero
    always_comb begin
        w_lz = '0;
        w_lz[NUM_DIGITS-1] = (r_digits[NUM_DIGITS-1] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            w_lz[i] = w_lz[i+1] && (r_digits[i] == 4'd0);
        end
    end

    // Next scan position and the glyph that digit will show
    always_comb begin
        w_step = (r_presc == PRE_W'(REFRESH_DIV - 1));
        if (!w_step) begin
            w_idx_next = r_idx;
        end else if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
            w_idx_next = '0;
        end else begin
            w_idx_next = r_idx + IDX_W'(1);
        end
        if (r_ovf) begin
            w_glyph = 7'b0000001;
        end else if (BLANK_LZ && (w_idx_next != '0) && w_lz[w_idx_next]) begin
            w_glyph = 7'b0000000;
        end else begin
            w_glyph = hex_glyph(r_digits[w_idx_next]);
        end
    end

    // Load capture, decimal conversion and display-register update
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_val      <= '0;
            r_hex_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_lost     <= 1'b0;
            r_dp_cap   <= '0;
            r_digits   <= '0;
            r_ovf      <= 1'b0;
            r_dp_disp  <= '0;
        end else begin
            if (r_hex_pend) begin
                r_digits   <= w_ext[DIG_W-1:0];
                r_ovf      <= w_hex_ovf;
                r_dp_disp  <= r_dp_cap;
                r_hex_pend <= 1'b0;
            end
            if (r_busy) begin
                r_bcd  <= w_bcd_next;
                r_val  <= r_val << 1;
                r_lost <= r_lost | w_bcd_adj[BCD_W-1];
                r_cnt  <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(BIN_WIDTH - 1)) begin
                    r_busy    <= 1'b0;
                    r_digits  <= w_bcd_next[DIG_W-1:0];
                    r_ovf     <= (w_bcd_next[BCD_W-1 -: 4] != 4'd0) || r_lost || w_bcd_adj[BCD_W-1];
                    r_dp_disp <= r_dp_cap;
                end
            end else if (io_bus.load) begin
                r_val      <= io_bus.value;
                r_dp_cap   <= io_bus.dp;
                r_hex_pend <= io_bus.hex_mode;
                r_busy     <= ~io_bus.hex_mode;
                r_cnt      <= '0;
                r_bcd      <= '0;
                r_lost     <= 1'b0;
            end
        end
    end

    // Refresh prescaler, digit scan and registered pin drive
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_seg   <= 8'hFF;
            r_an    <= '1;
        end else if (!io_bus.enable) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_seg   <= 8'hFF;
            r_an    <= '1;
        end else begin
            r_presc <= w_step ? '0 : (r_presc + PRE_W'(1));
            r_idx   <= w_idx_next;
            r_seg   <= ~{w_glyph, r_dp_disp[w_idx_next]};
            r_an    <= ~(NUM_DIGITS'(1) << w_idx_next);
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.overflow  = r_ovf;
    assign io_bus.digit_idx = r_idx;
    assign io_bus.seg_n     = r_seg;
    assign io_bus.an_n      = r_an;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multiplexed multi-digit 7-segment display driver with a parametrised digit count. It accepts a binary value and renders it in hex or in decimal. Decimal conversion is a sequential double-dabble. The driver time-multiplexes the digits through a refresh prescaler and drives active-low segment and anode lines directly to board pins. It sits between the processor's memory-mapped display register and the FPGA I/O, and supersedes the single-digit combinational decoder.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
BIN_WIDTH, 14, width of the binary input value
REFRESH_DIV, 50000, clocks each digit stays lit (>=2)
BLANK_LZ, 1, 1 = blank leading zeros (digit 0 always shown)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
load  in  1  request to capture value/hex_mode/dp
hex_mode  in  1  1 = hex nibbles, 0 = decimal
value  in  BIN_WIDTH  binary value to display
dp  in  NUM_DIGITS  decimal-point enable per digit
enable  in  1  0 = display dark, scan held
busy  out  1  decimal conversion in progress
overflow  out  1  value not representable in NUM_DIGITS digits
digit_idx  out  max(1,clog2(NUM_DIGITS))  digit currently lit
seg_n  out  8  {a,b,c,d,e,f,g,dp}, active low
an_n  out  NUM_DIGITS  digit anodes, active low, one-hot when lit

Behaviour:
- Reset values: busy=0, overflow=0, digit_idx=0, prescaler=0, all digit regs=0, dp regs=0, seg_n=8'hFF, an_n=all ones. Reset mid-conversion aborts the conversion and discards the partial result.
- Load acceptance: load=1 while busy=0 is accepted, and value, hex_mode and dp are captured on that edge. Load while busy=1 is ignored, with no queueing.
- Hex load: the display register and overflow update on the edge after the accepting edge. busy stays 0.
- Hex overflow: set if BIN_WIDTH>4*NUM_DIGITS and any bit at or above 4*NUM_DIGITS is nonzero.
- Decimal load: busy rises on the accepting edge and stays high for exactly BIN_WIDTH cycles.
- Double-dabble step: each cycle, add 3 to every BCD nibble >=5, then shift left one bit, shifting in the value MSB first.
- BCD width: NUM_DIGITS nibbles plus one carry nibble.
- Decimal completion: on the edge busy falls, the display register and overflow update.
- Decimal overflow: the carry nibble is nonzero, i.e. value >= 10^NUM_DIGITS.
- Overflow display: every digit shows '-' (g only) and dp is still honoured.
- Glyphs, a..g with 1 = lit:
  0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011.
  A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  '-'=0000001.
- Segment output: seg_n = ~{glyph,dp}.
- Leading-zero blanking (BLANK_LZ=1): digits above the most significant nonzero digit show glyph 0000000. Digit 0 is never blanked. The dp bit of a blanked digit still follows dp. Blanking does not apply when overflow=1.
- Scan: the prescaler counts 0..REFRESH_DIV-1. On the terminal count it returns to 0 and digit_idx increments, wrapping from NUM_DIGITS-1 to 0.
- Output timing: seg_n and an_n are registered and change on the same edge as digit_idx. an_n has bit digit_idx low and all other bits high.
- A display-register update takes effect on the lit digit on the next clock edge, without waiting for a scan step.
- enable=0: the prescaler and digit_idx are held at 0, and seg_n=8'hFF, an_n=all ones from the next edge. Conversion and loads continue to work.
- enable rising: digit 0 lights on the next edge.
- Simultaneous events: a scan step coinciding with a display update shows the new data on the new digit.

Test Plan:
- Reset then enable=1, no load -> digit_idx=0, an_n=1110, seg_n=8'b00000011 ('0'). Digits 1..3 blanked (seg_n=8'hFF when lit).
- hex_mode=1, value=14'h0A3, load 1 cycle -> busy stays 0. Digit0 seg_n=8'b00001101 ('3'), digit1 8'b00010001 ('A'), digits 2,3 8'hFF. overflow=0.
- hex_mode=0, value=1234, load -> busy=1 for exactly 14 cycles. Then digit3..0 show 1,2,3,4: seg_n 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001.
- hex_mode=0, value=10000 -> after 14 busy cycles overflow=1 and every digit seg_n=8'b11111101. A second load with value=9 during busy is ignored, and the display still shows the overflow result.
- REFRESH_DIV=4 -> digit_idx sequence 0,1,2,3,0 with each index held 4 clocks, an_n tracking. Deassert enable -> next edge an_n=1111, seg_n=8'hFF, digit_idx=0.
- Assert reset 5 cycles into a decimal conversion of 9999 -> asynchronously busy=0, seg_n=8'hFF, an_n=1111. After release and enable, '0' is shown.
